bpsk_bit_serializer: RTL and testbench



---
 rtl/bpsk_pkg.sv | 25 ++
 rtl/bpsk_sym_timer.sv | 45 ++++
 rtl/bpsk_bit_serializer.sv | 137 +++++++++++++
 tb/tb_bpsk_bit_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_pkg
// Description : Shared types and constants for the BPSK bit serializer:
//               FSM state encoding, default word width / samples-per-symbol,
//               and a counter-width helper that never returns zero.
// Revision    : 1.0 - initial release
// ============================================================================
package bpsk_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bpsk_state_t;

  localparam int BPSK_DATA_WIDTH = 8;
  localparam int BPSK_SPS        = 16;

  // Counter width for a modulo-n counter; at least one bit even for n <= 2.
  function automatic int bpsk_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpsk_sym_timer.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_sym_timer
// Description : Samples-per-symbol counter. Counts 0..SPS-1 while enabled and
//               wraps; a synchronous clear restarts the symbol.
// Ports       : clk, rst (async active-high)
//               en        - count enable (serializer is transmitting)
//               clr       - synchronous clear to sample 0
//               sym_end   - counter is at SPS-1 (last cycle of the symbol)
//               sym_start - enabled and counter is at 0 (first cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_sym_timer
  import bpsk_pkg::*;
#(
  parameter int SPS = BPSK_SPS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sym_end,
  output logic sym_start
);

  localparam int            CW   = bpsk_width(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic [CW-1:0] samp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt <= '0;
    end else if (clr) begin
      samp_cnt <= '0;
    end else if (en) begin
      samp_cnt <= sym_end ? '0 : samp_cnt + CW'(1);
    end
  end

  assign sym_end   = (samp_cnt == LAST);
  assign sym_start = en && (samp_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bpsk_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_bit_serializer
// Description : Accepts parallel words over valid/ready and serialises them,
//               holding each bit SPS cycles on sel_sig (carrier-phase select
//               for the downstream BPSK mux). A handshake in the very last
//               cycle of a word chains the next word with no gap.
// Ports       : clk, rst (async active-high)
//               data_in_sig   - word to transmit, sampled only on handshake
//               valid_in_sig  - source has a word
//               ready_out_sig - word accepted this cycle if valid
//               sel_sig       - registered symbol level (0 = phase 0, 1 = pi)
//               sym_stb_sig   - pulse in the first cycle of every symbol
//               busy_sig      - a word is being transmitted
// Options     : define BPSK_DIFF_ENC_EN for differential (DBPSK) encoding;
//               sel_sig then toggles on 1-bits and holds its level in idle.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_bit_serializer
  import bpsk_pkg::*;
#(
  parameter int DATA_WIDTH = BPSK_DATA_WIDTH,
  parameter int SPS        = BPSK_SPS,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_sig,
  input  logic                  valid_in_sig,
  output logic                  ready_out_sig,
  output logic                  sel_sig,
  output logic                  sym_stb_sig,
  output logic                  busy_sig
);

  localparam int            BW       = bpsk_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  bpsk_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]         bit_cnt;
  logic                  sel_q;
  logic                  sym_end, sym_start;
  logic                  in_shift, last_cycle, ready, load, advance;

  // Bit currently at the transmit end of a word.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Level driven for a data bit. In DBPSK mode sel_q doubles as the
  // reference level, so it must never be cleared except by reset.
  function automatic logic encode(input logic b, input logic ref_level);
`ifdef BPSK_DIFF_ENC_EN
    return ref_level ^ b;
`else
    return b ^ (ref_level & 1'b0);
`endif
  endfunction

  bpsk_sym_timer #(
    .SPS (SPS)
  ) u_sym_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (in_shift),
    .clr       (load),
    .sym_end   (sym_end),
    .sym_start (sym_start)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake decode.
  always_comb begin
    in_shift   = (state == ST_SHIFT);
    last_cycle = 1'b0;
    ready      = 1'b1;
    load       = 1'b0;
    advance    = 1'b0;
    state_nxt  = state;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        load  = valid_in_sig;
        if (load) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        last_cycle = sym_end && (bit_cnt == LAST_BIT);
        ready      = last_cycle;
        load       = valid_in_sig && last_cycle;
        advance    = sym_end && !last_cycle;
        if (last_cycle && !load) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign shreg_nxt = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[DATA_WIDTH-1:1]};

  // Datapath: shift register, bit counter and the registered symbol level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sel_q   <= 1'b0;
    end else if (load) begin
      shreg   <= data_in_sig;
      bit_cnt <= '0;
      sel_q   <= encode(head_bit(data_in_sig), sel_q);
    end else if (advance) begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt + BW'(1);
      sel_q   <= encode(head_bit(shreg_nxt), sel_q);
    end else if (last_cycle) begin
      bit_cnt <= '0;
`ifndef BPSK_DIFF_ENC_EN
      sel_q   <= 1'b0;
`endif
    end
  end

  assign ready_out_sig = ready;
  assign sel_sig       = sel_q;
  assign sym_stb_sig   = sym_start;
  assign busy_sig      = in_shift;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_bit_serializer
// Description : Self-checking bench for bpsk_bit_serializer (DATA_WIDTH=8,
//               SPS=16, MSB first). A queue-based reference model expands
//               every accepted word into its per-cycle symbol stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_bit_serializer;

  localparam int DW  = 8;
  localparam int SPS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in_sig = '0;
  logic          valid_in_sig = 1'b0;
  logic          ready_out_sig, sel_sig, sym_stb_sig, busy_sig;

  bpsk_bit_serializer #(
    .DATA_WIDTH (DW),
    .SPS        (SPS),
    .MSB_FIRST  (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_sig   (data_in_sig),
    .valid_in_sig  (valid_in_sig),
    .ready_out_sig (ready_out_sig),
    .sel_sig       (sel_sig),
    .sym_stb_sig   (sym_stb_sig),
    .busy_sig      (busy_sig)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one {strobe, level} entry per output cycle.
  logic [1:0] q[$];
  logic       m_sel = 1'b0, m_stb = 1'b0, m_busy = 1'b0;
  logic       push_level = 1'b0;
  logic       last_level = 1'b0;

  task automatic model_reset();
    q.delete();
    m_sel = 1'b0; m_stb = 1'b0; m_busy = 1'b0;
    push_level = 1'b0; last_level = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    logic b, lvl;
    for (int i = 0; i < DW; i++) begin
      b = w[DW-1-i];
`ifdef BPSK_DIFF_ENC_EN
      push_level = push_level ^ b;
      lvl = push_level;
`else
      lvl = b;
`endif
      for (int s = 0; s < SPS; s++) q.push_back({(s == 0), lvl});
    end
  endtask

  function automatic logic idle_level();
`ifdef BPSK_DIFF_ENC_EN
    return last_level;
`else
    return 1'b0;
`endif
  endfunction

  // Values sampled by the latest step, for scenario-level checks.
  logic s_sel, s_stb, s_busy, s_ready;

  // One clock: check outputs against the model, drive inputs, advance.
  task automatic step(input logic v, input logic [DW-1:0] d);
    logic [1:0] it;
    logic       m_ready;
    @(negedge clk);
    m_ready = (q.size() == 0);
    s_sel = sel_sig; s_stb = sym_stb_sig; s_busy = busy_sig; s_ready = ready_out_sig;
    chk("sel",   sel_sig,       m_sel);
    chk("stb",   sym_stb_sig,   m_stb);
    chk("busy",  busy_sig,      m_busy);
    chk("ready", ready_out_sig, m_ready);
    valid_in_sig = v;
    data_in_sig  = d;
    if (v && m_ready) push_word(d);
    @(posedge clk);
    if (q.size() > 0) begin
      it = q.pop_front();
      m_sel = it[0]; m_stb = it[1]; m_busy = 1'b1;
      last_level = it[0];
    end else begin
      m_sel = idle_level(); m_stb = 1'b0; m_busy = 1'b0;
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic [DW-1:0] exp_plain;  // levels in transmit order, first at bit DW-1
    logic [DW-1:0] exp_diff;   // same, differential, chained from reset level 0
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [DW-1:0] exp;
    int rdy_cnt, rdy_idx, stb_cnt;

    vecs[0] = '{8'hA5, 8'hA5, 8'hC6};
    vecs[1] = '{8'hC0, 8'hC0, 8'h80};
    vecs[2] = '{8'h80, 8'h80, 8'hFF};
    vecs[3] = '{8'h0F, 8'h0F, 8'hF5};
    vecs[4] = '{8'h3C, 8'h3C, 8'hD7};

    // Reset state, then 100 idle cycles with no valid.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel",   sel_sig,       1'b0);
    chk("rst_busy",  busy_sig,      1'b0);
    chk("rst_ready", ready_out_sig, 1'b1);
    chk("rst_stb",   sym_stb_sig,   1'b0);
    #2 rst = 1'b0;
    repeat (100) step(1'b0, DW'($urandom));

    // Table-driven single words, each followed by an idle cycle.
    foreach (vecs[r]) begin
`ifdef BPSK_DIFF_ENC_EN
      exp = vecs[r].exp_diff;
`else
      exp = vecs[r].exp_plain;
`endif
      step(1'b1, vecs[r].word);
      for (int k = 0; k < DW * SPS; k++) begin
        step(1'b0, DW'($urandom));
        chk("tbl_sel",  s_sel,  exp[DW-1-(k/SPS)]);
        chk("tbl_stb",  s_stb,  (k % SPS) == 0);
        chk("tbl_busy", s_busy, 1'b1);
      end
      step(1'b0, DW'($urandom));
      chk("tbl_idle_busy", s_busy, 1'b0);
      chk("tbl_idle_sel",  s_sel,  exp[0] & idle_level() | (exp[0] & 1'b0) | idle_level());
    end

    // Back-to-back F0 then 0F with valid held.
    step(1'b1, 8'hF0);
    rdy_cnt = 0; rdy_idx = -1; stb_cnt = 0;
    for (int k = 0; k < DW * SPS; k++) begin
      step(1'b1, 8'h0F);
      if (s_ready) begin rdy_cnt++; rdy_idx = k; end
      if (s_stb) stb_cnt++;
    end
    for (int k = 0; k < DW * SPS; k++) begin
      step(1'b0, DW'($urandom));
      if (s_stb) stb_cnt++;
    end
    chk("b2b_ready_pulses", rdy_cnt, 1);
    chk("b2b_ready_cycle",  rdy_idx, DW * SPS - 1);
    chk("b2b_strobes",      stb_cnt, 2 * DW);
    step(1'b0, '0);
    chk("b2b_done_busy", s_busy, 1'b0);

    // Reset 40 cycles into word FF, then a clean word.
    step(1'b1, 8'hFF);
    repeat (40) step(1'b0, DW'($urandom));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel",   sel_sig,       1'b0);
    chk("mid_rst_busy",  busy_sig,      1'b0);
    chk("mid_rst_ready", ready_out_sig, 1'b1);
    chk("mid_rst_stb",   sym_stb_sig,   1'b0);
    model_reset();
    #1 rst = 1'b0;
    step(1'b1, 8'h3C);
    repeat (DW * SPS + 4) step(1'b0, DW'($urandom));

    // Randomized valid and wiggling data, checked against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 3) == 0), DW'($urandom));
    end
    repeat (DW * SPS + 2) step(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
